// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch-stage bundle between fetch unit, memory and decode
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
);
    logic                   stall;
    logic                   redirect_en;
    logic [PC_WIDTH-1:0]    redirect_addr;
    logic                   halt;
    logic [INSTR_WIDTH-1:0] instr_mem_out;
    logic [PC_WIDTH-1:0]    prog_ctr;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;
    logic                   halted;
    logic [CNT_WIDTH-1:0]   fetch_count;

    modport master (
        input  stall, redirect_en, redirect_addr, halt, instr_mem_out,
        output prog_ctr, instr_out, instr_pc, instr_valid, halted, fetch_count
    );

    modport slave (
        output stall, redirect_en, redirect_addr, halt, instr_mem_out,
        input  prog_ctr, instr_out, instr_pc, instr_valid, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC and fetch stage with stall hold, redirect flush, halt and fetch counter
module instr_fetch_unit #(
    parameter int                  PC_WIDTH    = 10,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e                 state_q,       state_d;
    logic [PC_WIDTH-1:0]    prog_ctr_q,    prog_ctr_d;
    logic [PC_WIDTH-1:0]    pc_q,          pc_d;
    logic [INSTR_WIDTH-1:0] hold_instr_q,  hold_instr_d;
    logic [PC_WIDTH-1:0]    hold_pc_q,     hold_pc_d;
    logic                   use_hold_q,    use_hold_d;
    logic                   flush_q,       flush_d;
    logic                   first_q,       first_d;
    logic [CNT_WIDTH-1:0]   fetch_count_q, fetch_count_d;

    logic [INSTR_WIDTH-1:0] instr_sel;
    logic [PC_WIDTH-1:0]    pc_sel;
    logic                   valid;

    always_comb begin
        instr_sel = use_hold_q ? hold_instr_q : bus.instr_mem_out;
        pc_sel    = use_hold_q ? hold_pc_q    : pc_q;
        valid     = (state_q == RUN) && !flush_q && !first_q;
    end

    always_comb begin
        state_d       = state_q;
        prog_ctr_d    = prog_ctr_q;
        pc_d          = prog_ctr_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        use_hold_d    = use_hold_q;
        flush_d       = flush_q;
        first_d       = 1'b0;
        fetch_count_d = fetch_count_q;

        case (state_q)
            BOOT: begin
                // memory has just been handed RESET_PC; its data lands one cycle into RUN
                state_d = RUN;
                first_d = 1'b1;
            end
            RUN: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.redirect_en) begin
                    prog_ctr_d = bus.redirect_addr;
                    use_hold_d = 1'b0;
                    flush_d    = 1'b1;
                end else if (bus.stall) begin
                    // flush is left alone so a stalled bubble stays a bubble
                    hold_instr_d = instr_sel;
                    hold_pc_d    = pc_sel;
                    use_hold_d   = 1'b1;
                end else begin
                    prog_ctr_d = prog_ctr_q + PC_WIDTH'(1);
                    use_hold_d = 1'b0;
                    flush_d    = 1'b0;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (valid && !bus.stall && (state_q == RUN) && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            prog_ctr_q    <= RESET_PC;
            pc_q          <= '0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
            use_hold_q    <= 1'b0;
            flush_q       <= 1'b0;
            first_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            prog_ctr_q    <= prog_ctr_d;
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            use_hold_q    <= use_hold_d;
            flush_q       <= flush_d;
            first_q       <= first_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.prog_ctr    = prog_ctr_q;
    assign bus.instr_out   = instr_sel;
    assign bus.instr_pc    = pc_sel;
    assign bus.instr_valid = valid;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam int PW = 10;
    localparam int IW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    instr_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC('0), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [IW-1:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
    end
    always @(posedge clk) bus.instr_mem_out <= mem[bus.prog_ctr];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic          stall;
        logic          redir;
        logic [PW-1:0] addr;
        logic          halt;
        logic          valid;
        logic [PW-1:0] pc;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vt [27];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [PW-1:0] a, input logic h);
        bus.stall         = s;
        bus.redirect_en   = r;
        bus.redirect_addr = a;
        bus.halt          = h;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_boot();
        chk("boot_prog_ctr", 32'(bus.prog_ctr), 32'h0);
        chk("boot_valid", 32'(bus.instr_valid), 32'h0);
        chk("boot_halted", 32'(bus.halted), 32'h0);
        chk("boot_count", 32'(bus.fetch_count), 32'h0);
        chk("boot_instr_pc", 32'(bus.instr_pc), 32'h0);
    endtask

    logic [PW-1:0] frozen_pc;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'd0};
        vt[1]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 16'd1};
        vt[2]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 16'd2};
        vt[3]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h003, 16'd3};
        vt[4]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h004, 16'd4};
        vt[5]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 16'd5};
        vt[6]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 16'd5};
        vt[7]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 16'd5};
        vt[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 16'd5};
        vt[9]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h006, 16'd6};
        vt[10] = '{1'b0, 1'b1, 10'h200, 1'b0, 1'b1, 10'h007, 16'd7};
        vt[11] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'd8};
        vt[12] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h200, 16'd8};
        vt[13] = '{1'b1, 1'b1, 10'h100, 1'b0, 1'b1, 10'h201, 16'd9};
        vt[14] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'd9};
        vt[15] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h100, 16'd9};
        vt[16] = '{1'b0, 1'b1, 10'h3FE, 1'b0, 1'b1, 10'h101, 16'd10};
        vt[17] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'd11};
        vt[18] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h3FE, 16'd11};
        vt[19] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h3FF, 16'd12};
        vt[20] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'd13};
        vt[21] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 16'd14};
        vt[22] = '{1'b0, 1'b1, 10'h050, 1'b0, 1'b1, 10'h002, 16'd15};
        vt[23] = '{1'b0, 1'b1, 10'h060, 1'b0, 1'b0, 10'h000, 16'd16};
        vt[24] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'd16};
        vt[25] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h060, 16'd16};
        vt[26] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h061, 16'd17};

        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        do_reset();
        check_boot();
        step();
        chk("first_run_valid", 32'(bus.instr_valid), 32'h0);

        step();
        for (int i = 0; i < 27; i++) begin
            drive(vt[i].stall, vt[i].redir, vt[i].addr, vt[i].halt);
            chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(vt[i].valid));
            chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'h0);
            chk($sformatf("v%0d_count", i), 32'(bus.fetch_count), 32'(vt[i].cnt));
            if (vt[i].valid) begin
                chk($sformatf("v%0d_pc", i), 32'(bus.instr_pc), 32'(vt[i].pc));
                chk($sformatf("v%0d_instr", i), 32'(bus.instr_out), 32'h1000 + 32'(vt[i].pc));
            end
            step();
        end

        for (int k = 0; k < 3; k++) begin
            drive(k[0], 1'b1, 10'h123, 1'b0);
            chk("halt_halted", 32'(bus.halted), 32'h1);
            chk("halt_valid", 32'(bus.instr_valid), 32'h0);
            chk("halt_prog_ctr", 32'(bus.prog_ctr), 32'h062);
            chk("halt_count", 32'(bus.fetch_count), 32'd18);
            step();
        end

        do_reset();
        drive(1'b1, 1'b1, 10'h2AA, 1'b1);
        check_boot();
        step();
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("boot_ignored_halted", 32'(bus.halted), 32'h0);
        chk("boot_ignored_prog_ctr", 32'(bus.prog_ctr), 32'h0);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("pre_stall_pc", 32'(bus.instr_pc), 32'(k));
            if (k == 2) drive(1'b1, 1'b0, '0, 1'b0);
            step();
        end
        chk("mid_stall_pc", 32'(bus.instr_pc), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        check_boot();
        step();
        chk("restart_first_valid", 32'(bus.instr_valid), 32'h0);
        step();
        for (int k = 0; k < 10; k++) begin
            chk("run_valid", 32'(bus.instr_valid), 32'h1);
            chk("run_pc", 32'(bus.instr_pc), 32'(k));
            chk("run_instr", 32'(bus.instr_out), 32'h1000 + 32'(k));
            if (k == 9) drive(1'b0, 1'b0, '0, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        frozen_pc = bus.prog_ctr;
        chk("halt2_prog_ctr", 32'(frozen_pc), 32'd10);
        for (int k = 0; k < 2; k++) begin
            chk("halt2_halted", 32'(bus.halted), 32'h1);
            chk("halt2_valid", 32'(bus.instr_valid), 32'h0);
            chk("halt2_count", 32'(bus.fetch_count), 32'd10);
            chk("halt2_frozen", 32'(bus.prog_ctr), 32'(frozen_pc));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
